memwb: RTL and testbench

MEMWB -- requirements
Module: memwb

---
 rtl/memwb_pkg.sv | 21 ++
 rtl/memwb_mem_lane.sv | 26 ++
 rtl/memwb.sv | 118 +++++++++++
 tb/tb_memwb.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared configuration for the memory/writeback stage: default widths,
// state encoding and byte-lane select codes.
package memwb_pkg;

    localparam int RW_DEF    = 16;
    localparam int REGNO_DEF = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MEM  = 1'b1;

    localparam logic [1:0] SEL_WORD = 2'b11;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_HI   = 2'b10;

    function automatic logic [1:0] lane_sel(input logic byte_op, input logic addr0);
        if (!byte_op)
            return SEL_WORD;
        return addr0 ? SEL_HI : SEL_LO;
    endfunction

endpackage

// File: rtl/memwb_mem_lane.sv
// Byte-lane select, store replication and load extraction for a 16-bit bus.
module mem_lane
    import memwb_pkg::*;
#(
    parameter int RW = RW_DEF
) (
    input  logic          byte_op,
    input  logic          addr0,
    input  logic [RW-1:0] wdata_in,
    input  logic [RW-1:0] rdata_in,
    output logic [1:0]    sel,
    output logic [RW-1:0] wdata_out,
    output logic [RW-1:0] rdata_out
);

    logic [7:0] rd_byte;

    always_comb begin
        sel       = lane_sel(byte_op, addr0);
        wdata_out = byte_op ? {(RW/8){wdata_in[7:0]}} : wdata_in;
        // odd byte addresses live in the upper lane
        rd_byte   = addr0 ? rdata_in[15:8] : rdata_in[7:0];
        rdata_out = byte_op ? {{(RW-8){1'b0}}, rd_byte} : rdata_in;
    end

endmodule

// File: rtl/memwb.sv
// Memory/writeback stage: passes ALU results to the register file or runs one
// data-bus transaction, with a wait counter that bounds how long it stalls.
module memwb
    import memwb_pkg::*;
#(
    parameter int RW      = RW_DEF,
    parameter int REGNO   = REGNO_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_submit,
    output logic             o_ready,
    input  logic [RW-1:0]    i_addr,
    input  logic [RW-1:0]    i_data,
    input  logic [REGNO-1:0] i_reg_ie,
    input  logic             i_mem_access,
    input  logic             i_mem_we,
    input  logic             i_mem_width,
    output logic [REGNO-1:0] o_reg_ie,
    output logic [RW-1:0]    o_reg_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [RW-1:0]    o_mem_addr,
    output logic [RW-1:0]    o_mem_data,
    output logic [1:0]       o_mem_sel,
    input  logic             i_mem_ack,
    input  logic             i_mem_err,
    input  logic [RW-1:0]    i_mem_data,
    output logic             o_bus_fault
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [0:0]       state;
    logic [CW-1:0]    wait_cnt;
    logic [RW-1:0]    addr_q;
    logic [RW-1:0]    data_q;
    logic             we_q;
    logic             byte_q;
    logic [REGNO-1:0] reg_ie_q;
    logic [RW-1:0]    rd_ext;

    logic in_mem;
    logic tmo;
    logic done;
    logic fault;
    logic ld_ok;

    mem_lane #(.RW(RW)) u_lane (
        .byte_op   (byte_q),
        .addr0     (addr_q[0]),
        .wdata_in  (data_q),
        .rdata_in  (i_mem_data),
        .sel       (o_mem_sel),
        .wdata_out (o_mem_data),
        .rdata_out (rd_ext)
    );

    always_comb begin
        in_mem = (state == ST_MEM);
        tmo    = (wait_cnt == CW'(TIMEOUT));
        done   = in_mem && (i_mem_ack || i_mem_err || tmo);
        // err beats ack; a timeout coinciding with ack is a normal completion
        fault  = in_mem && (i_mem_err || (tmo && !i_mem_ack));
        ld_ok  = in_mem && i_mem_ack && !i_mem_err && !we_q;
    end

    assign o_ready    = (state == ST_IDLE);
    assign o_mem_req  = in_mem;
    assign o_mem_addr = addr_q;
    assign o_mem_we   = we_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            reg_ie_q    <= '0;
            o_reg_ie    <= '0;
            o_reg_data  <= '0;
            o_bus_fault <= 1'b0;
        end else begin
            o_reg_ie    <= '0;
            o_bus_fault <= fault;
            if (state == ST_IDLE) begin
                if (i_submit) begin
                    if (i_mem_access) begin
                        state    <= ST_MEM;
                        wait_cnt <= '0;
                        addr_q   <= i_addr;
                        data_q   <= i_data;
                        we_q     <= i_mem_we;
                        byte_q   <= i_mem_width;
                        reg_ie_q <= i_reg_ie;
                    end else begin
                        o_reg_ie   <= i_reg_ie;
                        o_reg_data <= i_data;
                    end
                end
            end else begin
                if (done) begin
                    state <= ST_IDLE;
                    if (ld_ok) begin
                        o_reg_ie   <= reg_ie_q;
                        o_reg_data <= rd_ext;
                    end
                end else if (!tmo) begin
                    wait_cnt <= wait_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_memwb.sv
// Scoreboard bench for memwb: expected register writes are queued at submit
// time and consumed by a negedge monitor whenever the stage writes.
module tb_memwb;

    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_submit = 1'b0;
    logic        o_ready;
    logic [15:0] i_addr = '0;
    logic [15:0] i_data = '0;
    logic [7:0]  i_reg_ie = '0;
    logic        i_mem_access = 1'b0;
    logic        i_mem_we = 1'b0;
    logic        i_mem_width = 1'b0;
    logic [7:0]  o_reg_ie;
    logic [15:0] o_reg_data;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_data;
    logic [1:0]  o_mem_sel;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_err = 1'b0;
    logic [15:0] i_mem_data = '0;
    logic        o_bus_fault;

    typedef struct {
        logic [7:0]  ie;
        logic [15:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  faults_seen = 0;
    bit  mon_en = 1'b0;

    memwb #(.RW(16), .REGNO(8), .TIMEOUT(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_submit     (i_submit),
        .o_ready      (o_ready),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_reg_ie     (i_reg_ie),
        .i_mem_access (i_mem_access),
        .i_mem_we     (i_mem_we),
        .i_mem_width  (i_mem_width),
        .o_reg_ie     (o_reg_ie),
        .o_reg_data   (o_reg_data),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_mem_sel    (o_mem_sel),
        .i_mem_ack    (i_mem_ack),
        .i_mem_err    (i_mem_err),
        .i_mem_data   (i_mem_data),
        .o_bus_fault  (o_bus_fault)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_bus_fault === 1'b1)
                faults_seen++;
            if (o_reg_ie !== 8'h00) begin
                wr_t e;
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got ie=%h data=%h required no write", o_reg_ie, o_reg_data);
                end else begin
                    e = sb.pop_front();
                    if (o_reg_ie !== e.ie || o_reg_data !== e.data) begin
                        failures++;
                        $display("FAIL reg_write got ie=%h data=%h required ie=%h data=%h",
                                 o_reg_ie, o_reg_data, e.ie, e.data);
                    end
                end
            end
        end
    end

    task automatic submit(input logic mem, input logic we, input logic width,
                          input logic [15:0] addr, input logic [15:0] data, input logic [7:0] ie);
        @(posedge i_clk); #1;
        i_submit = 1'b1; i_mem_access = mem; i_mem_we = we; i_mem_width = width;
        i_addr = addr; i_data = data; i_reg_ie = ie;
        @(posedge i_clk); #1;
        i_submit = 1'b0; i_mem_access = 1'b0; i_mem_we = 1'b0; i_mem_width = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1 || o_mem_req !== 1'b0 || o_mem_we !== 1'b0 ||
            o_reg_ie !== 8'h00 || o_reg_data !== 16'h0000 || o_bus_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b req=%b we=%b ie=%h data=%h flt=%b required 1 0 0 00 0000 0",
                     o_ready, o_mem_req, o_mem_we, o_reg_ie, o_reg_data, o_bus_fault);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_nonmem();
        sb.push_back('{ie: 8'h04, data: 16'h1234});
        submit(1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 8'h04);
        @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin
            failures++;
            $display("FAIL nonmem_ready got %b required 1", o_ready);
        end
        @(posedge i_clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL nonmem_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_word_load();
        int req_cycles = 0;
        sb.push_back('{ie: 8'h02, data: 16'hBEEF});
        submit(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 8'h02);
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            if (o_mem_req === 1'b1) req_cycles++;
            checks++;
            if (o_ready !== 1'b0 || o_mem_sel !== 2'b11 || o_mem_addr !== 16'h0040 || o_mem_we !== 1'b0) begin
                failures++;
                $display("FAIL word_load_bus k=%0d got rdy=%b sel=%b addr=%h we=%b required 0 11 0040 0",
                         k, o_ready, o_mem_sel, o_mem_addr, o_mem_we);
            end
            // a submit while busy must be dropped
            i_submit = (k == 1); i_reg_ie = 8'h10; i_data = 16'hDEAD;
            if (k == 3) begin
                i_mem_ack = 1'b1; i_mem_data = 16'hBEEF;
            end
        end
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0; i_submit = 1'b0;
        @(negedge i_clk);
        checks++;
        if (req_cycles != 4 || o_mem_req !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL word_load_req got cycles=%0d req=%b rdy=%b required 4 0 1", req_cycles, o_mem_req, o_ready);
        end
        @(posedge i_clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL word_load_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_byte_load();
        sb.push_back('{ie: 8'h80, data: 16'h00A5});
        submit(1'b1, 1'b0, 1'b1, 16'h0041, 16'h0000, 8'h80);
        @(negedge i_clk);
        checks++;
        if (o_mem_sel !== 2'b10 || o_mem_req !== 1'b1) begin
            failures++;
            $display("FAIL byte_load_sel got sel=%b req=%b required 10 1", o_mem_sel, o_mem_req);
        end
        i_mem_ack = 1'b1; i_mem_data = 16'hA55A;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL byte_load_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_byte_store();
        submit(1'b1, 1'b1, 1'b1, 16'h0010, 16'h12C3, 8'h01);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            checks++;
            if (o_mem_data !== 16'hC3C3 || o_mem_sel !== 2'b01 || o_mem_we !== 1'b1 || o_mem_req !== 1'b1) begin
                failures++;
                $display("FAIL byte_store k=%0d got data=%h sel=%b we=%b req=%b required C3C3 01 1 1",
                         k, o_mem_data, o_mem_sel, o_mem_we, o_mem_req);
            end
            if (k == 1) i_mem_ack = 1'b1;
        end
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_reg_ie !== 8'h00) begin
            failures++;
            $display("FAIL byte_store_done got req=%b ie=%h required 0 00", o_mem_req, o_reg_ie);
        end
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int f0 = faults_seen;
        submit(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 8'h08);
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_mem_req !== 1'b1) break;
            req_cycles++;
        end
        checks++;
        if (req_cycles != TMO + 1 || o_bus_fault !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len got req_cycles=%0d fault=%b required %0d 1", req_cycles, o_bus_fault, TMO + 1);
        end
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if (faults_seen - f0 != 1 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_fault got pulses=%0d rdy=%b required 1 1", faults_seen - f0, o_ready);
        end
    endtask

    task automatic test_ack_err();
        int f0 = faults_seen;
        submit(1'b1, 1'b0, 1'b0, 16'h0022, 16'h0000, 8'h20);
        @(negedge i_clk);
        i_mem_ack = 1'b1; i_mem_err = 1'b1; i_mem_data = 16'h5555;
        @(posedge i_clk); #1;
        i_mem_ack = 1'b0; i_mem_err = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_bus_fault !== 1'b1 || o_reg_ie !== 8'h00 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL ack_err got fault=%b ie=%h req=%b required 1 00 0", o_bus_fault, o_reg_ie, o_mem_req);
        end
        @(posedge i_clk); #1;
        checks++;
        if (faults_seen - f0 != 1) begin
            failures++;
            $display("FAIL ack_err_pulse got %0d required 1", faults_seen - f0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d;
        @(posedge i_clk); #1;
        for (int k = 0; k < 4; k++) begin
            d = 16'h1000 + 16'(k * 16'h0111);
            i_submit = 1'b1; i_mem_access = 1'b0; i_data = d; i_reg_ie = 8'(1 << k);
            sb.push_back('{ie: 8'(1 << k), data: d});
            @(negedge i_clk);
            checks++;
            if (o_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready k=%0d got %b required 1", k, o_ready);
            end
            @(posedge i_clk); #1;
        end
        i_submit = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_mem();
        int f0 = faults_seen;
        submit(1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 8'h40);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_mem_req !== 1'b0 || o_ready !== 1'b1 || o_reg_ie !== 8'h00 || o_bus_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mem got req=%b rdy=%b ie=%h fault=%b required 0 1 00 0",
                     o_mem_req, o_ready, o_reg_ie, o_bus_fault);
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (faults_seen != f0 || o_mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got pulses=%0d req=%b required 0 0", faults_seen - f0, o_mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_word_load();
        test_byte_load();
        test_byte_store();
        test_timeout();
        test_ack_err();
        test_back_to_back();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
